rat_intr_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the RAT MCU's INTR input and on its I/O port bus (PORT_ID, OUT_PORT, IO_STRB, IN_PORT). It synchronises up to 8 external interrupt sources and latches each as pending, in per-source edge or level mode. Sources are masked under software control, and a single combined INTR is driven into the MCU. Firmware uses OUT/IN instructions to program mask and mode, read pending status and a priority-encoded source ID, and clear serviced requests.

---
 rtl/rat_io_pkg.sv | 20 ++
 rtl/rat_intr_ctrl_if.sv | 21 ++
 rtl/rat_intr_ctrl_irq_sync_edge.sv | 32 +++
 rtl/rat_intr_ctrl.sv | 86 ++++++++
 tb/tb_rat_intr_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rat_io_pkg.sv
// Shared constants for the RAT interrupt controller: register offsets,
// the "no source pending" ID, and the priority-encoder helper.
package rat_io_pkg;

   localparam logic [1:0] OFS_MASK = 2'd0;
   localparam logic [1:0] OFS_PEND = 2'd1;
   localparam logic [1:0] OFS_MODE = 2'd2;
   localparam logic [1:0] OFS_ID   = 2'd3;

   localparam logic [7:0] ID_NONE  = 8'hFF;

   // Index of the lowest set bit, or ID_NONE when the vector is empty.
   function automatic logic [7:0] lowest_set_id(input logic [7:0] vec);
      lowest_set_id = ID_NONE;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) lowest_set_id = 8'(i);
      end
   endfunction

endpackage

// File: rtl/rat_intr_ctrl_if.sv
// RAT MCU I/O port bus as seen by a peripheral: address, write data and
// strobe from the MCU; read data and address-hit back to the IN_PORT mux.
interface rat_intr_ctrl_if;

   logic [7:0] PORT_ID;
   logic [7:0] OUT_PORT;
   logic       IO_STRB;
   logic [7:0] IN_PORT;
   logic       RD_HIT;

   modport master (
      output PORT_ID, OUT_PORT, IO_STRB,
      input  IN_PORT, RD_HIT
   );

   modport slave (
      input  PORT_ID, OUT_PORT, IO_STRB,
      output IN_PORT, RD_HIT
   );

endinterface

// File: rtl/rat_intr_ctrl_irq_sync_edge.sv
// Per-bit multi-flop synchroniser for asynchronous request lines, followed
// by one extra flop so a synchronised rising edge can be detected.
module irq_sync_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] irq_i,
   output logic [WIDTH-1:0] s_o,
   output logic [WIDTH-1:0] rise_o
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  edge_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, giving a true shift chain.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q <= '0;
         edge_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Interrupt controller for the RAT MCU: pends up to 8 synchronised sources in
// edge or level mode, masks them, and drives a registered combined INTR.
module rat_intr_ctrl
   import rat_io_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR   = 8'h20,
   parameter int         N_SRC       = 8,
   parameter int         SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [N_SRC-1:0] IRQ_SRC,
   rat_intr_ctrl_if.slave   bus,
   output logic             INTR
);

   localparam logic [7:0] SRC_MASK = 8'((1 << N_SRC) - 1);

   logic [N_SRC-1:0] s, rise;
   logic [7:0]       s_ext, rise_ext, set_vec, clr_vec;
   logic [7:0]       addr_diff;
   logic [1:0]       ofs;
   logic             hit, wr_en;
   logic [7:0]       mask_q, mode_q, pend_q, pend_d;
   logic             intr_q;
   logic [7:0]       rd_data;

   irq_sync_edge #(
      .WIDTH       (N_SRC),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .irq_i   (IRQ_SRC),
      .s_o     (s),
      .rise_o  (rise)
   );

   // Offset arithmetic lets BASE_ADDR sit on any address, not just 4-aligned.
   assign addr_diff = bus.PORT_ID - BASE_ADDR;
   assign ofs       = addr_diff[1:0];
   assign hit       = (addr_diff[7:2] == 6'd0);
   assign wr_en     = bus.IO_STRB & hit;

   assign s_ext    = 8'(s);
   assign rise_ext = 8'(rise);
   assign set_vec  = ((mode_q & rise_ext) | (~mode_q & s_ext)) & SRC_MASK;
   assign clr_vec  = (wr_en && ofs == OFS_PEND) ? bus.OUT_PORT : 8'h00;

   // Set is OR-ed in after the clear so a same-cycle request is never lost.
   assign pend_d = ((pend_q & ~clr_vec) | set_vec) & SRC_MASK;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mask_q <= 8'h00;
         mode_q <= 8'h00;
         pend_q <= 8'h00;
         intr_q <= 1'b0;
      end else begin
         if (wr_en && ofs == OFS_MASK) mask_q <= bus.OUT_PORT;
         if (wr_en && ofs == OFS_MODE) mode_q <= bus.OUT_PORT;
         pend_q <= pend_d;
         intr_q <= |(pend_q & mask_q);
      end
   end

   // NOTE: rd_data gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rd_data = 8'h00;
      if (hit) begin
         case (ofs)
            OFS_MASK: rd_data = mask_q;
            OFS_PEND: rd_data = pend_q;
            OFS_MODE: rd_data = mode_q;
            OFS_ID:   rd_data = lowest_set_id(pend_q & mask_q);
            default:  rd_data = 8'h00;
         endcase
      end
   end

   assign bus.IN_PORT = rd_data;
   assign bus.RD_HIT  = hit;
   assign INTR        = intr_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed self-checking bench for rat_intr_ctrl: reset state, edge latency,
// masking/priority, level re-pend, set/clear collision and async reset.
module tb_rat_intr_ctrl;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] IRQ_SRC;
   logic       INTR;

   int n_assert = 0;
   int n_fail   = 0;

   rat_intr_ctrl_if bus_if ();

   rat_intr_ctrl #(
      .BASE_ADDR   (8'h20),
      .N_SRC       (8),
      .SYNC_STAGES (2)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .IRQ_SRC (IRQ_SRC),
      .bus     (bus_if.slave),
      .INTR    (INTR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; sampling happens 1ns after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      bus_if.PORT_ID  = addr;
      bus_if.OUT_PORT = data;
      bus_if.IO_STRB  = 1'b1;
      tick();
      bus_if.IO_STRB  = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
      bus_if.PORT_ID = addr;
      #1;
      check(tag, bus_if.IN_PORT, exp);
   endtask

   initial begin
      RESET_N         = 1'b0;
      IRQ_SRC         = 8'h00;
      bus_if.PORT_ID  = 8'h00;
      bus_if.OUT_PORT = 8'h00;
      bus_if.IO_STRB  = 1'b0;

      // 1. Reset / idle
      repeat (3) tick();
      RESET_N = 1'b1;
      tick();
      rd(8'h20, 8'h00, "rst_mask");
      rd(8'h21, 8'h00, "rst_pend");
      rd(8'h22, 8'h00, "rst_mode");
      rd(8'h23, 8'hFF, "rst_id");
      check("rst_intr", {7'd0, INTR}, 8'h00);
      rd(8'h23, 8'hFF, "hit_top_data");
      check("hit_top", {7'd0, bus_if.RD_HIT}, 8'h01);
      rd(8'h50, 8'h00, "miss_data");
      check("miss_hit", {7'd0, bus_if.RD_HIT}, 8'h00);
      rd(8'h24, 8'h00, "miss_above_data");
      check("miss_above_hit", {7'd0, bus_if.RD_HIT}, 8'h00);

      // 2. Edge-mode latency on source 2
      wr(8'h22, 8'hFF);
      wr(8'h20, 8'h04);
      IRQ_SRC = 8'h04;
      tick();
      tick();
      rd(8'h21, 8'h00, "lat_pend_e2");
      tick();
      rd(8'h21, 8'h04, "lat_pend_e3");
      check("lat_intr_e3", {7'd0, INTR}, 8'h00);
      IRQ_SRC = 8'h00;
      tick();
      check("lat_intr_e4", {7'd0, INTR}, 8'h01);
      rd(8'h23, 8'h02, "lat_id");
      wr(8'h21, 8'h04);
      rd(8'h21, 8'h00, "lat_w1c_pend");
      check("lat_w1c_intr_same", {7'd0, INTR}, 8'h01);
      tick();
      check("lat_w1c_intr_next", {7'd0, INTR}, 8'h00);

      // Out-of-range and ID writes are ignored
      wr(8'h24, 8'hAA);
      wr(8'h1F, 8'h55);
      wr(8'h23, 8'h00);
      rd(8'h20, 8'h04, "ignore_wr_mask");
      rd(8'h22, 8'hFF, "ignore_wr_mode");

      // 3. Masked pending and priority
      wr(8'h20, 8'h00);
      IRQ_SRC = 8'h22;
      repeat (3) tick();
      IRQ_SRC = 8'h00;
      repeat (3) tick();
      rd(8'h21, 8'h22, "mskd_pend");
      check("mskd_intr", {7'd0, INTR}, 8'h00);
      rd(8'h23, 8'hFF, "mskd_id");
      wr(8'h20, 8'hFF);
      check("unmask_intr_same", {7'd0, INTR}, 8'h00);
      tick();
      check("unmask_intr_next", {7'd0, INTR}, 8'h01);
      rd(8'h23, 8'h01, "prio_id_1");
      wr(8'h21, 8'h02);
      rd(8'h23, 8'h05, "prio_id_5");
      rd(8'h21, 8'h20, "prio_pend");
      wr(8'h22, 8'h00);
      rd(8'h21, 8'h20, "mode_keeps_pend");
      wr(8'h21, 8'h20);
      rd(8'h21, 8'h00, "prio_clr_all");

      // 4. Level-mode re-pend
      wr(8'h20, 8'h01);
      IRQ_SRC = 8'h01;
      repeat (4) tick();
      rd(8'h21, 8'h01, "lvl_pend");
      check("lvl_intr", {7'd0, INTR}, 8'h01);
      wr(8'h21, 8'h01);
      rd(8'h21, 8'h01, "lvl_repend");
      tick();
      check("lvl_intr_held", {7'd0, INTR}, 8'h01);
      IRQ_SRC = 8'h00;
      repeat (3) tick();
      wr(8'h21, 8'h01);
      rd(8'h21, 8'h00, "lvl_clr");
      tick();
      check("lvl_intr_low", {7'd0, INTR}, 8'h00);

      // 5. Set/clear collision on source 3: W1C lands on the rise cycle
      wr(8'h22, 8'hFF);
      wr(8'h20, 8'h08);
      IRQ_SRC = 8'h08;
      tick();
      tick();
      wr(8'h21, 8'h08);
      rd(8'h21, 8'h08, "coll_set_wins");
      wr(8'h21, 8'h08);
      rd(8'h21, 8'h00, "coll_later_clr");
      IRQ_SRC = 8'h00;
      repeat (3) tick();

      // 6. Async reset mid-cycle
      wr(8'h22, 8'h00);
      wr(8'h20, 8'hFF);
      IRQ_SRC = 8'hFF;
      repeat (4) tick();
      rd(8'h21, 8'hFF, "pre_rst_pend");
      check("pre_rst_intr", {7'd0, INTR}, 8'h01);
      #1;
      RESET_N = 1'b0;
      #1;
      check("arst_pend", bus_if.IN_PORT, 8'h00);
      check("arst_intr", {7'd0, INTR}, 8'h00);
      rd(8'h20, 8'h00, "arst_mask");
      IRQ_SRC = 8'h00;
      tick();
      RESET_N = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
